mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit serving the ALU execute stage for MIPS mult, multu, div and divu.
- Operands arrive on the same op_src_1 / op_src_2 buses the ALU uses.
- Results land in architectural HI/LO registers, which are read through the hi/lo outputs for mfhi/mflo.
- Execute stage starts an operation and stalls on busy; writeback reads HI/LO once done pulses.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- md_op  input  2  00 mult, 01 multu, 10 div, 11 divu
- op_src_1  input  WIDTH  multiplicand / dividend
- op_src_2  input  WIDTH  multiplier / divisor
- hi_we  input  1  mthi write enable
- lo_we  input  1  mtlo write enable
- wdata  input  WIDTH  mthi/mtlo data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: async on rst=1. State=IDLE; hi, lo, busy, done, counter and internal registers all cleared to 0. Applies mid-operation; the in-flight result is discarded.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge T:
  - Latch operands and md_op.
  - For signed ops, latch absolute values plus sign flags.
  - Counter=0; go to CALC; busy=1 from cycle T+1.
- CALC, multiply: 32 shift-add steps on a 64-bit product (unsigned magnitudes). One bit per cycle.
- CALC, divide: 32 restoring steps (remainder shift, trial subtract, quotient bit). One bit per cycle.
- CALC exit: after the 32nd step -> FIX.
- FIX, signed correction:
  - mult: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- FIX, writeback: at the edge leaving FIX, {hi,lo} <= product; or hi <= remainder, lo <= quotient.
- FIX, handshake: done=1 for exactly the following cycle; busy=0 in that same cycle.
- Latency: start at edge T; busy high for cycles T+1..T+33; done high and new hi/lo visible in cycle T+34.
- Back-to-back: a new start is accepted at the edge on which done is high.
- start while busy: ignored.
- hi_we/lo_we:
  - Effective only in IDLE with start=0; update at the next edge.
  - Ignored while busy.
  - If start=1 in the same cycle, start wins and the write is dropped.
  - hi_we and lo_we together: both registers get wdata.
- Divide by zero: completes with normal latency and no trap. hi = op_src_1 (original, unsigned/signed as given); lo = all ones.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operand capture: operand inputs are sampled only at the start edge; later changes have no effect.
- Output stability: hi/lo hold their values throughout CALC/FIX; results never partially update.

Test Plan:
- mult, op1=0xFFFFFFFD (-3), op2=5 -> done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- multu, 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 0x1234/0 -> hi=0x00001234, lo=0xFFFFFFFF, done at T+34.
- Handshake/mthi:
  - start pulsed again at T+5 -> ignored.
  - hi_we with wdata=0xAA at T+10 -> hi unchanged.
  - After done, mtlo 0x55 -> lo=0x55 next cycle.
  - start+hi_we together in IDLE -> operation runs and the write is dropped.
- Reset mid-op: start mult, assert rst at T+15 -> busy=0, done=0, hi=lo=0 immediately (async). After release, a fresh multu 3x4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mul_div_if.sv
// Handshake and operand/result bundle between the execute stage and the mul/div unit.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] op_src_1;
  logic [WIDTH-1:0] op_src_2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, op_src_1, op_src_2, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, op_src_1, op_src_2, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS mult/multu/div/divu unit: one bit per cycle on magnitudes,
// sign correction in a final FIX cycle, results written to HI/LO.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  mul_div_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_orig_a;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_a;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_signed;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_signed = ~bus.md_op[0];
    w_neg1   = w_signed & bus.op_src_1[WIDTH-1];
    w_neg2   = w_signed & bus.op_src_2[WIDTH-1];
    w_abs1   = w_neg1 ? -bus.op_src_1 : bus.op_src_1;
    w_abs2   = w_neg2 ? -bus.op_src_2 : bus.op_src_2;

    w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

    // Restoring step: a borrow out of the trial subtract means keep the shifted remainder.
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_m};
    if (w_diff[WIDTH]) begin
      w_div_next = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end

    w_prod = r_neg_res ? -r_acc : r_acc;
    w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_m       <= '0;
      r_orig_a  <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_b_zero  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state   <= StCalc;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_is_div  <= bus.md_op[1];
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg_a   <= w_neg1;
            r_b_zero  <= (bus.op_src_2 == '0);
            r_orig_a  <= bus.op_src_1;
            if (bus.md_op[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_abs1};
              r_m   <= w_abs2;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_abs2};
              r_m   <= w_abs1;
            end
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        StCalc: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntW'(WIDTH - 1)) r_state <= StFix;
        end
        StFix: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_b_zero) begin
            r_hi <= r_orig_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} as the architecture defines them.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin
        q = sa * sb;
        p = q;
      end
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inj, input bit with_we);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int          cyc, lat;
    bit          stable, got;
    exp = model(op, a, b);
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start    = 1'b1;
    bus.md_op    = op;
    bus.op_src_1 = a;
    bus.op_src_2 = b;
    if (with_we) begin
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.md_op    = 2'($urandom);
    bus.op_src_1 = $urandom;
    bus.op_src_2 = $urandom;
    cyc = 0; lat = 0; stable = 1'b1; got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (bus.busy) cyc++;
      if (bus.hi !== hi0 || bus.lo !== lo0) stable = 1'b0;
      if (inj && k == 5) begin
        bus.start    = 1'b1;
        bus.md_op    = 2'd1;
        bus.op_src_1 = $urandom;
      end
      if (inj && k == 6) bus.start = 1'b0;
      if (inj && k == 10) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_00AA;
      end
      if (inj && k == 11) bus.hi_we = 1'b0;
    end
    chk({tag, " done"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'd34);
    chk({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " hold"}, 64'(stable), 64'd1);
    chk({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
  endtask

  initial begin
    logic [31:0] hsave;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.md_op = 2'd0; bus.op_src_1 = '0; bus.op_src_2 = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    #3;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_by0", 2'd3, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_op("div_by0_neg", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);

    hsave = bus.hi;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0055;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo lo", 64'(bus.lo), 64'h55);
    chk("mtlo hi_kept", 64'(bus.hi), 64'(hsave));

    run_op("start_with_we", 2'd1, 32'd7, 32'd9, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if (i % 4 == 3) rb = 32'd0;
      else if (i % 4 == 1) rb = $urandom_range(1, 255);
      else rb = $urandom;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0, 1'b0);
    end

    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1357;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthi_mtlo hi", 64'(bus.hi), 64'h1357);
    chk("mthi_mtlo lo", 64'(bus.lo), 64'h1357);

    bus.start    = 1'b1;
    bus.md_op    = 2'd0;
    bus.op_src_1 = 32'd1000;
    bus.op_src_2 = 32'd1000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst done", 64'(bus.done), 64'd0);
    chk("midrst hi", 64'(bus.hi), 64'd0);
    chk("midrst lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst_multu", 2'd1, 32'd3, 32'd4, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
